fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of PC_Register. Consumes PC, issues a

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/ifid_latch.sv | 33 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, IF/ID pipeline latch contents, fetch FSM states.
// Types and defaults only; no timing or flow-control content.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

  localparam word_t PC_INCR_DEFAULT   = 32'd4;
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: one-cycle load, clear (flush) beats load, load beats bubble.
// No backpressure of its own; with no enable asserted the contents hold.
module ifid_latch
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load,
  input  logic  clear,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
      q.pc    <= '0;
      q.npc   <= '0;
    end else if (clear) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= d;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: level imem read at PC, capture into IF/ID in the ihit cycle (zero-wait on hit).
// On ID stall a fetched word parks in a one-entry hold buffer and the PC stops; halt freezes until reset.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INCR   = PC_INCR_DEFAULT,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t PC,
  input  logic  halt,
  input  logic  flush,
  input  logic  stall,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  pc_adv,
  output word_t npc,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc
);

  fetch_state_t state, next_state;

  word_t buf_instr, buf_pc, buf_npc;
  logic  buf_ld;
  logic  ld, clr, inval;
  logic  ren_int, adv_int;
  ifid_t ifid_d, ifid_q;

  assign imemaddr = PC;
  assign npc      = PC + PC_INCR;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (ihit && stall) next_state = HOLD;
      HOLD:    if (!stall)        next_state = FETCH;
      default: next_state = HALTED;
    endcase
    if (state != HALTED && flush) next_state = FETCH;
    if (halt)                     next_state = HALTED;
  end

  always_comb begin
    ren_int = 1'b0;
    adv_int = 1'b0;
    ld      = 1'b0;
    clr     = 1'b0;
    inval   = 1'b0;
    buf_ld  = 1'b0;
    if (!halt && state != HALTED) begin
      ren_int = (state == FETCH);
      if (flush) begin
        clr     = 1'b1;
        adv_int = 1'b1;
      end else if (state == FETCH) begin
        if (stall) begin
          buf_ld = ihit;
        end else if (ihit) begin
          ld      = 1'b1;
          adv_int = 1'b1;
        end else begin
          inval = 1'b1;
        end
      end else if (!stall) begin
        ld      = 1'b1;
        adv_int = 1'b1;
      end
    end
  end

  // Gating with nRST makes the request vanish as soon as reset asserts, not at the next edge.
  assign imemREN = ren_int & nRST;
  assign pc_adv  = adv_int & nRST;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      buf_instr <= '0;
      buf_pc    <= '0;
      buf_npc   <= '0;
    end else if (clr) begin
      buf_instr <= '0;
      buf_pc    <= '0;
      buf_npc   <= '0;
    end else if (buf_ld) begin
      buf_instr <= imemload;
      buf_pc    <= PC;
      buf_npc   <= npc;
    end
  end

  always_comb begin
    ifid_d.valid = 1'b1;
    if (state == HOLD) begin
      ifid_d.instr = buf_instr;
      ifid_d.pc    = buf_pc;
      ifid_d.npc   = buf_npc;
    end else begin
      ifid_d.instr = imemload;
      ifid_d.pc    = PC;
      ifid_d.npc   = npc;
    end
  end

  ifid_latch #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .CLK    (CLK),
    .nRST   (nRST),
    .load   (ld),
    .clear  (clr),
    .bubble (inval),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ifid_valid = ifid_q.valid;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_npc   = ifid_q.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] PC;
  logic        halt, flush, stall, ihit;
  logic [31:0] imemload;
  logic        imemREN, pc_adv, ifid_valid;
  logic [31:0] imemaddr, npc, ifid_instr, ifid_pc, ifid_npc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .PC         (PC),
    .halt       (halt),
    .flush      (flush),
    .stall      (stall),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .pc_adv     (pc_adv),
    .npc        (npc),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_npc   (ifid_npc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 unit after a rising edge; checks land 1 unit later, far from the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p, input logic [31:0] np);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    check({tag, ".instr"}, ifid_instr, ins);
    check({tag, ".pc"},    ifid_pc, p);
    check({tag, ".npc"},   ifid_npc, np);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_ifid(tag, 1'b0, 32'h0, 32'h0, 32'h0);
    check({tag, ".imemREN"}, {31'd0, imemREN}, 32'd0);
    check({tag, ".pc_adv"},  {31'd0, pc_adv},  32'd0);
  endtask

  initial begin
    nRST = 1'b0; PC = 32'h0; halt = 1'b0; flush = 1'b0; stall = 1'b0;
    ihit = 1'b0; imemload = 32'h0;
    #2;
    check_reset_outputs("reset");
    tick();
    nRST = 1'b1;

    // 1: straight hit
    PC = 32'h0; ihit = 1'b1; imemload = 32'h8C010004;
    #1;
    check("t1.imemREN", {31'd0, imemREN}, 32'd1);
    check("t1.pc_adv",  {31'd0, pc_adv},  32'd1);
    check("t1.imemaddr", imemaddr, 32'h0);
    check("t1.npc", npc, 32'h4);
    tick();
    check_ifid("t1.ifid", 1'b1, 32'h8C010004, 32'h0, 32'h4);
    check("t1.imemREN2", {31'd0, imemREN}, 32'd1);

    // 2: hit under stall parks in hold buffer, drains when stall drops
    PC = 32'h10; stall = 1'b1; imemload = 32'h12345678;
    #1;
    check("t2.adv_stall", {31'd0, pc_adv}, 32'd0);
    tick();
    ihit = 1'b0;
    #1;
    check("t2.hold_ren", {31'd0, imemREN}, 32'd0);
    check("t2.hold_adv", {31'd0, pc_adv},  32'd0);
    check_ifid("t2.held", 1'b1, 32'h8C010004, 32'h0, 32'h4);
    tick();
    stall = 1'b0;
    #1;
    check("t2.drain_adv", {31'd0, pc_adv}, 32'd1);
    tick();
    check_ifid("t2.drained", 1'b1, 32'h12345678, 32'h10, 32'h14);
    check("t2.adv_once", {31'd0, pc_adv}, 32'd0);
    check("t2.ren_back", {31'd0, imemREN}, 32'd1);

    // 3: flush beats stall and discards the hit
    PC = 32'h20; ihit = 1'b1; stall = 1'b1; flush = 1'b1; imemload = 32'hDEADBEEF;
    #1;
    check("t3.adv", {31'd0, pc_adv}, 32'd1);
    tick();
    flush = 1'b0; stall = 1'b0; ihit = 1'b0;
    #1;
    check("t3.valid", {31'd0, ifid_valid}, 32'd0);
    check("t3.instr", ifid_instr, 32'h0);
    check("t3.fetch_ren", {31'd0, imemREN}, 32'd1);

    // 4: halt beats flush and ihit, then sticks until reset
    PC = 32'h40; ihit = 1'b1; imemload = 32'hAABBCCDD;
    tick();
    check_ifid("t4.pre", 1'b1, 32'hAABBCCDD, 32'h40, 32'h44);
    PC = 32'h44; halt = 1'b1; flush = 1'b1; imemload = 32'h11111111;
    #1;
    check("t4.adv",  {31'd0, pc_adv},  32'd0);
    check("t4.ren",  {31'd0, imemREN}, 32'd0);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flush = i[0];
      #1;
      check("t4.halted_adv", {31'd0, pc_adv},  32'd0);
      check("t4.halted_ren", {31'd0, imemREN}, 32'd0);
      tick();
    end
    check_ifid("t4.frozen", 1'b1, 32'hAABBCCDD, 32'h40, 32'h44);
    flush = 1'b0; ihit = 1'b0;
    nRST = 1'b0;
    #1;
    check_reset_outputs("t4.reset");
    tick();
    nRST = 1'b1;

    // 5: npc wraps; misses bubble IF/ID
    PC = 32'hFFFFFFFC; ihit = 1'b1; imemload = 32'h00000020;
    #1;
    check("t5.npc_wrap", npc, 32'h0);
    tick();
    check_ifid("t5.wrap", 1'b1, 32'h00000020, 32'hFFFFFFFC, 32'h0);
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5.miss_adv", {31'd0, pc_adv}, 32'd0);
      tick();
      check("t5.bubble", {31'd0, ifid_valid}, 32'd0);
    end

    // 6: reset mid-fetch drops the request before the next edge
    PC = 32'h80; ihit = 1'b0;
    #1;
    check("t6.ren_pre", {31'd0, imemREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("t6.ren_async", {31'd0, imemREN}, 32'd0);
    tick();
    nRST = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
